// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the two-requester memory arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default address and data widths
//   state_e                 : 2-bit FSM encoding (IDLE=0, ISSUE=1, WAIT_DATA=2)
//   pick_winner()           : 2-way round-robin winner selection
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DATA = 2'd2
  } state_e;

  // A lone requester always wins; with both pending the pointer decides.
  function automatic logic pick_winner(logic r0, logic r1, logic prio);
    logic idx;
    if (r0 && r1) begin
      idx = prio;
    end else begin
      idx = r1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the requester handshakes and the memory port.
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 : requester -> arbiter
//   ack0/ack1, rdata, busy                         : arbiter -> requester
//   mem_en, mem_we, mem_addr, mem_din              : arbiter -> memory
//   mem_dout                                       : memory -> arbiter
// Modports: slave = arbiter side, master = requester/memory side.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    output ack0, ack1, rdata, busy, mem_en, mem_we, mem_addr, mem_din
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    input  ack0, ack1, rdata, busy, mem_en, mem_we, mem_addr, mem_din
  );

endinterface

// File: rtl/mem_arbiter_arb_rr2.sv
// arb_rr2: two-way round-robin winner selection with its priority pointer.
//   clk, reset : clock, synchronous active-high reset (pointer -> 0)
//   req0_i     : request from requester 0
//   req1_i     : request from requester 1
//   update_i   : end-of-access strobe; moves the pointer to the loser
//   gnt_idx_o  : index of the selected requester
//   gnt_vld_o  : at least one request present
// The pointer only moves when both requests are present at the strobe, so a
// lone requester never disturbs the fairness order.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0_i,
  input  logic req1_i,
  input  logic update_i,
  output logic gnt_idx_o,
  output logic gnt_vld_o
);

  logic prio_q;
  logic prio_d;
  logic gnt_idx_s;
  logic gnt_vld_s;

  // Winner selection and next pointer value.
  always_comb begin
    gnt_vld_s = req0_i | req1_i;
    gnt_idx_s = pick_winner(req0_i, req1_i, prio_q);
    prio_d    = prio_q;
    if (update_i && req0_i && req1_i) begin
      prio_d = ~gnt_idx_s;
    end else begin
      prio_d = prio_q;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

  assign gnt_idx_o = gnt_idx_s;
  assign gnt_vld_o = gnt_vld_s;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between two
// requesters. Every access is IDLE -> ISSUE -> WAIT_DATA -> IDLE.
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : mem_arbiter_if.slave (requester handshakes + memory port)
// Outputs are decoded from registered state only; rdata is a gated view of
// mem_dout because the memory already supplies one cycle of latency.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  state_e            state_q, state_d;
  logic              win_q, win_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  // Snapshot of both requests at the IDLE sample, replayed to the arbiter
  // at the end of the access so the pointer update sees the original
  // contention rather than whatever the requesters drive by then.
  logic              snap0_q, snap0_d;
  logic              snap1_q, snap1_d;

  logic              arb_req0_s;
  logic              arb_req1_s;
  logic              arb_upd_s;
  logic              gnt_idx_s;
  logic              gnt_vld_s;

  logic              ack0_s;
  logic              ack1_s;
  logic              busy_s;
  logic              mem_en_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_din_s;
  logic [DATA_W-1:0] rdata_s;

  // Live requests in IDLE, latched snapshot for the rest of the access.
  always_comb begin
    if (state_q == IDLE) begin
      arb_req0_s = bus.req0;
      arb_req1_s = bus.req1;
    end else begin
      arb_req0_s = snap0_q;
      arb_req1_s = snap1_q;
    end
    arb_upd_s = (state_q == WAIT_DATA);
  end

  arb_rr2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req0_i    (arb_req0_s),
    .req1_i    (arb_req1_s),
    .update_i  (arb_upd_s),
    .gnt_idx_o (gnt_idx_s),
    .gnt_vld_o (gnt_vld_s)
  );

  // Next-state logic and request latching.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    snap0_d = snap0_q;
    snap1_d = snap1_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld_s) begin
          state_d = ISSUE;
          win_d   = gnt_idx_s;
          snap0_d = bus.req0;
          snap1_d = bus.req1;
          if (gnt_idx_s == 1'b0) begin
            we_d    = bus.we0;
            addr_d  = bus.addr0;
            wdata_d = bus.wdata0;
          end else begin
            we_d    = bus.we1;
            addr_d  = bus.addr1;
            wdata_d = bus.wdata1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE:     state_d = WAIT_DATA;
      WAIT_DATA: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // State and latched-request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      snap0_q <= 1'b0;
      snap1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      snap0_q <= snap0_d;
      snap1_q <= snap1_d;
    end
  end

  // Output decode. Outputs are forced low while reset is high so that an
  // access caught by reset in ISSUE or WAIT_DATA neither writes the memory
  // nor delivers an ack.
  always_comb begin
    ack0_s     = 1'b0;
    ack1_s     = 1'b0;
    busy_s     = 1'b0;
    mem_en_s   = 1'b0;
    mem_we_s   = 1'b0;
    mem_addr_s = '0;
    mem_din_s  = '0;
    rdata_s    = '0;
    if (!reset) begin
      busy_s = (state_q != IDLE);
      case (state_q)
        ISSUE: begin
          mem_en_s   = 1'b1;
          mem_we_s   = we_q;
          mem_addr_s = addr_q;
          mem_din_s  = wdata_q;
        end
        WAIT_DATA: begin
          ack0_s  = ~win_q;
          ack1_s  = win_q;
          rdata_s = bus.mem_dout;
        end
        default: begin
          busy_s = (state_q != IDLE);
        end
      endcase
    end else begin
      busy_s = 1'b0;
    end
  end

  assign bus.ack0     = ack0_s;
  assign bus.ack1     = ack1_s;
  assign bus.busy     = busy_s;
  assign bus.mem_en   = mem_en_s;
  assign bus.mem_we   = mem_we_s;
  assign bus.mem_addr = mem_addr_s;
  assign bus.mem_din  = mem_din_s;
  assign bus.rdata    = rdata_s;

endmodule
